// File: rtl/order_display_sequencer_if.sv
// Button/switch inputs and display-side outputs of the order display sequencer.
// The master modport drives buttons and switches; the slave modport is the sequencer.
interface order_display_sequencer_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    logic              btnU;
    logic              btnD;
    logic              btnL;
    logic              btnR;
    logic              sw15;
    logic              sw16;
    logic [2:0]        msg_sel;
    logic              msg_restart;
    logic              showing;
    logic [CountW-1:0] queue_count;
    logic              queue_full;
    logic              overflow;

    modport master (
        output btnU, btnD, btnL, btnR, sw15, sw16,
        input  msg_sel, msg_restart, showing, queue_count, queue_full, overflow
    );

    modport slave (
        input  btnU, btnD, btnL, btnR, sw15, sw16,
        output msg_sel, msg_restart, showing, queue_count, queue_full, overflow
    );
endinterface

// File: rtl/order_display_sequencer.sv
// Debounces four menu buttons, queues accepted orders in a FIFO and plays them back
// one at a time on the scrolling sign via msg_sel / msg_restart.
module order_display_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned DWELL_CYCLES    = 300_000_000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input logic                      clk,
    input logic                      rst,
    order_display_sequencer_if.slave bus_io
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);
    localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StShow} state_e;

    logic [3:0]        btn_raw, sync1_q, sync2_q, deb_q, deb_d, rise;
    logic [DbW-1:0]    db_cnt_q [4];
    logic [DbW-1:0]    db_cnt_d [4];
    logic [2:0]        press_code;
    logic              accept, push, pop;

    state_e            state_q, state_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [2:0]        msg_sel_q, msg_sel_d;
    logic              restart_q, restart_d;
    logic              ovf_q, ovf_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic [2:0]        mem_q [FIFO_DEPTH];

    assign btn_raw = {bus_io.btnR, bus_io.btnL, bus_io.btnD, bus_io.btnU};

    // Counter runs only while the synced level differs from the debounced one, so any
    // bounce back to the old level restarts it.
    always_comb begin
        deb_d = deb_q;
        rise  = '0;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    deb_d[i] = sync2_q[i];
                    rise[i]  = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        press_code = 3'd0;
        if (rise[0]) begin
            press_code = 3'd1;
        end else if (rise[1]) begin
            press_code = 3'd2;
        end else if (rise[2]) begin
            press_code = 3'd3;
        end else if (rise[3]) begin
            press_code = 3'd4;
        end
    end

    assign accept = bus_io.sw15 & bus_io.sw16 & (press_code != 3'd0);

    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        msg_sel_d = msg_sel_q;
        restart_d = 1'b0;
        ovf_d     = ovf_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (!bus_io.sw15) begin
            // Closing flushes everything and overrides any push or pop this cycle.
            state_d   = StIdle;
            dwell_d   = '0;
            msg_sel_d = 3'd0;
            restart_d = (msg_sel_q != 3'd0);
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (count_q != '0) state_d = StLoad;
                end
                StLoad: begin
                    pop       = 1'b1;
                    state_d   = StShow;
                    msg_sel_d = mem_q[rd_ptr_q];
                    restart_d = 1'b1;
                    dwell_d   = '0;
                end
                StShow: begin
                    if (dwell_q == DwellLast) begin
                        dwell_d = '0;
                        if (count_q != '0) begin
                            state_d = StLoad;
                        end else begin
                            state_d   = StIdle;
                            msg_sel_d = 3'd0;
                            restart_d = 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (accept) begin
                if (count_q == CountFull && !pop) begin
                    ovf_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (!bus_io.sw16) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            db_cnt_q  <= '{default: '0};
            state_q   <= StIdle;
            dwell_q   <= '0;
            msg_sel_q <= 3'd0;
            restart_q <= 1'b0;
            ovf_q     <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            msg_sel_q <= msg_sel_d;
            restart_q <= restart_d;
            ovf_q     <= ovf_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= press_code;
    end

    assign bus_io.msg_sel     = msg_sel_q;
    assign bus_io.msg_restart = restart_q;
    assign bus_io.showing     = (state_q == StShow);
    assign bus_io.queue_count = count_q;
    assign bus_io.queue_full  = (count_q == CountFull);
    assign bus_io.overflow    = ovf_q;
endmodule
